hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/rns_pipe_pkg.sv | 14 +
 rtl/hazard_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/rns_pipe_pkg.sv
// Shared RNS pipeline definitions: hazard FSM state encoding and register-address widths.
package rns_pipe_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int OP3_ADDR_W = 3;
  localparam int MC_CNT_W   = 4;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_WAIT = 2'd1,
    FLUSH   = 2'd2
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, multi-cycle RNS op freeze, taken-branch flush.
// Optional stall statistics counter is built only when HAZARD_CTRL_STATS_EN is defined.
module hazard_ctrl
  import rns_pipe_pkg::*;
#(
  parameter int MC_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_true_EX,
  input  logic [REG_ADDR_W-1:0] dest_addr_EX,
  input  logic [REG_ADDR_W-1:0] op1_addr_IFID,
  input  logic [REG_ADDR_W-1:0] op2_addr_IFID,
  input  logic [OP3_ADDR_W-1:0] op3_addr_IFID,
  input  logic [2:0]            op_used_IFID,
  input  logic                  mc_start_EX,
  input  logic                  branch_taken_EX,
`ifdef HAZARD_CTRL_STATS_EN
  output logic [CNT_W-1:0]      stall_cycles,
`endif
  output logic                  stall_PC,
  output logic                  stall_IFID,
  output logic                  stall_IDEX,
  output logic                  bubble_IDEX,
  output logic                  flush_IFID,
  output logic                  mc_busy,
  output logic                  mc_done
);

  if (MC_LATENCY < 2 || MC_LATENCY > 15 || CNT_W < 1) begin : g_bad_param
    $error("hazard_ctrl: MC_LATENCY must be 2..15 and CNT_W >= 1");
  end

  localparam logic [MC_CNT_W-1:0] MC_LOAD = MC_CNT_W'(MC_LATENCY - 2);

  hz_state_e             state_q, state_d;
  logic [MC_CNT_W-1:0]   mc_cnt_q, mc_cnt_d;

  logic hit1, hit2, hit3, load_use;
  logic stall_pc_c, stall_ifid_c, stall_idex_c, bubble_c, flush_c, busy_c, done_c;

  // op3 only names the lower half of the register file, so dest 8..15 never aliases it.
  assign hit1     = op_used_IFID[0] & (op1_addr_IFID == dest_addr_EX);
  assign hit2     = op_used_IFID[1] & (op2_addr_IFID == dest_addr_EX);
  assign hit3     = op_used_IFID[2] & ~dest_addr_EX[3] &
                    (op3_addr_IFID == dest_addr_EX[OP3_ADDR_W-1:0]);
  assign load_use = load_true_EX & (hit1 | hit2 | hit3);

  always_comb begin
    state_d      = state_q;
    mc_cnt_d     = mc_cnt_q;
    stall_pc_c   = 1'b0;
    stall_ifid_c = 1'b0;
    stall_idex_c = 1'b0;
    bubble_c     = 1'b0;
    flush_c      = 1'b0;
    busy_c       = 1'b0;
    done_c       = 1'b0;
    case (state_q)
      RUN: begin
        if (branch_taken_EX) begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
          state_d  = FLUSH;
        end else if (mc_start_EX) begin
          stall_pc_c   = 1'b1;
          stall_ifid_c = 1'b1;
          stall_idex_c = 1'b1;
          busy_c       = 1'b1;
          mc_cnt_d     = MC_LOAD;
          state_d      = MC_WAIT;
        end else if (load_use) begin
          stall_pc_c   = 1'b1;
          stall_ifid_c = 1'b1;
          bubble_c     = 1'b1;
        end
      end
      MC_WAIT: begin
        // EX is frozen: the pipeline holds until the edge that closes the done cycle.
        stall_pc_c   = 1'b1;
        stall_ifid_c = 1'b1;
        stall_idex_c = 1'b1;
        busy_c       = 1'b1;
        if (mc_cnt_q == '0) begin
          done_c  = 1'b1;
          state_d = RUN;
        end else begin
          mc_cnt_d = mc_cnt_q - 1'b1;
        end
      end
      FLUSH: begin
        flush_c = 1'b1;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Outputs are forced low for the whole time rst is high, independent of clk.
  assign stall_PC    = stall_pc_c   & ~rst;
  assign stall_IFID  = stall_ifid_c & ~rst;
  assign stall_IDEX  = stall_idex_c & ~rst;
  assign bubble_IDEX = bubble_c     & ~rst;
  assign flush_IFID  = flush_c      & ~rst;
  assign mc_busy     = busy_c       & ~rst;
  assign mc_done     = done_c       & ~rst;

`ifdef HAZARD_CTRL_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_pc_c && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  assign stall_cycles = stall_cnt_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      mc_cnt_q    <= '0;
`ifdef HAZARD_CTRL_STATS_EN
      stall_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mc_cnt_q    <= mc_cnt_d;
`ifdef HAZARD_CTRL_STATS_EN
      stall_cnt_q <= stall_cnt_d;
`endif
    end
  end

endmodule
